// File: rtl/decim_strobe_pkg.sv
// rtl/decim_strobe_pkg.sv - shared constants and rate-bus field helper for the decimation strobe chain
package decim_strobe_pkg;

    localparam int RATE_WIDTH_DEF = 16;
    localparam int NUM_STAGES_MAX = 8;
    localparam int RATE_WIDTH_MAX = 32;
    localparam int RATE_BUS_MAX   = NUM_STAGES_MAX * RATE_WIDTH_MAX;

    typedef logic [RATE_BUS_MAX-1:0]   rate_bus_t;
    typedef logic [RATE_WIDTH_MAX-1:0] rate_field_t;

    // Field k of a packed rate bus whose fields are w bits wide.
    function automatic rate_field_t rate_field(input rate_bus_t bus, input int unsigned k,
                                               input int unsigned w);
        rate_bus_t mask;
        rate_bus_t sh;
        mask = (rate_bus_t'(1) << w) - rate_bus_t'(1);
        sh   = (bus >> (k * w)) & mask;
        return rate_field_t'(sh);
    endfunction

endpackage

// File: rtl/decim_stage_counter.sv
// rtl/decim_stage_counter.sv - one decimation stage: event counter, shadow rate and registered strobe
module decim_stage_counter
    import decim_strobe_pkg::*;
#(
    parameter int RATE_WIDTH = RATE_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  ev_i,
    input  logic                  sync_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    output logic                  tc_o,
    output logic [RATE_WIDTH-1:0] rate_o,
    output logic                  strobe_o
);

    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic                  strobe_q, strobe_d;
    logic                  rate_zero;

    assign rate_zero = (rate_q == '0);
    assign tc_o      = ev_i & ~rate_zero & (cnt_q == rate_q - RATE_WIDTH'(1));

    // The shadow only reloads at a frame boundary, on resync, or while idle,
    // so a new rate never shortens or stretches a frame already in progress.
    always_comb begin
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        strobe_d = tc_o & ~sync_i;
        if (sync_i) begin
            cnt_d  = '0;
            rate_d = rate_i;
        end else if (en_i) begin
            if (ev_i && !rate_zero) begin
                cnt_d = tc_o ? '0 : cnt_q + RATE_WIDTH'(1);
            end
            if (tc_o || rate_zero) begin
                rate_d = rate_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            rate_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            strobe_q <= strobe_d;
        end
    end

    assign rate_o   = rate_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/decim_strobe_gen.sv
// rtl/decim_strobe_gen.sv - cascaded multi-rate decimation strobe generator driving the CIC act inputs
module decim_strobe_gen
    import decim_strobe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int RATE_WIDTH = RATE_WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             en_i,
    input  logic                             act_i,
    input  logic                             sync_i,
    input  logic [NUM_STAGES*RATE_WIDTH-1:0] rate_i,
    output logic [NUM_STAGES-1:0]            strobe_o,
    output logic [NUM_STAGES*RATE_WIDTH-1:0] rate_o
);

    logic [NUM_STAGES-1:0] ev;
    rate_bus_t             rate_bus;

    assign rate_bus = rate_bus_t'(rate_i);
    assign ev[0]    = act_i & en_i;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                  tc;
        logic                  stb;
        logic [RATE_WIDTH-1:0] stage_rate;
        logic [RATE_WIDTH-1:0] shadow;

        assign stage_rate = RATE_WIDTH'(rate_field(rate_bus, k, RATE_WIDTH));

        decim_stage_counter #(
            .RATE_WIDTH (RATE_WIDTH)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .en_i     (en_i),
            .ev_i     (ev[k]),
            .sync_i   (sync_i),
            .rate_i   (stage_rate),
            .tc_o     (tc),
            .rate_o   (shadow),
            .strobe_o (stb)
        );

        // Each stage's wrap is the count event of the next, keeping strobes coincident.
        if (k < NUM_STAGES - 1) begin : g_link
            assign ev[k+1] = tc;
        end else begin : g_last
            logic tc_unused;
            assign tc_unused = tc;
        end

        assign strobe_o[k]                          = stb;
        assign rate_o[k*RATE_WIDTH +: RATE_WIDTH]   = shadow;
    end

endmodule

// File: tb/tb_decim_strobe_gen.sv
// tb/tb_decim_strobe_gen.sv - self-checking bench for decim_strobe_gen
module tb_decim_strobe_gen;

    localparam int N = 3;
    localparam int W = 16;

    typedef struct packed {
        logic [N-1:0]   strobe;
        logic [N*W-1:0] rate;
    } exp_t;

    typedef struct {
        logic [W-1:0] r0, r1, r2;
        int n_acts, gap;
        int e0, e1, e2, last0;
    } vec_t;

    logic           clk_i = 1'b0;
    logic           rst_n_i, en_i, act_i, sync_i;
    logic [N*W-1:0] rate_i;
    logic [N-1:0]   strobe_o;
    logic [N*W-1:0] rate_o;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0, act_n = 0;
    int   m_cnt[N], m_r[N], s_cnt[N], last_act[N];
    vec_t tbl[6];

    always #5 clk_i = ~clk_i;

    decim_strobe_gen #(.NUM_STAGES(N), .RATE_WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (en_i),
        .act_i    (act_i),
        .sync_i   (sync_i),
        .rate_i   (rate_i),
        .strobe_o (strobe_o),
        .rate_o   (rate_o)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic set_rates(input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2);
        rate_i = {r2, r1, r0};
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            m_r[k]   = 0;
        end
        sb.delete();
    endtask

    task automatic tally_clear();
        act_n = 0;
        for (int k = 0; k < N; k++) begin
            s_cnt[k]    = 0;
            last_act[k] = -1;
        end
    endtask

    // Drive one cycle, predict the registered outputs, then compare after the edge.
    task automatic step(input logic en, input logic act, input logic sync);
        exp_t e;
        logic ev, tc;
        int   f;
        en_i   = en;
        act_i  = act;
        sync_i = sync;
        ev = act & en;
        for (int k = 0; k < N; k++) begin
            f  = int'(rate_i[k*W +: W]);
            tc = ev && (m_r[k] != 0) && (m_cnt[k] == m_r[k] - 1);
            e.strobe[k] = tc && !sync;
            if (sync) begin
                m_cnt[k] = 0;
                m_r[k]   = f;
            end else if (en) begin
                if (ev && m_r[k] != 0) m_cnt[k] = tc ? 0 : m_cnt[k] + 1;
                if (tc || m_r[k] == 0) m_r[k] = f;
            end
            e.rate[k*W +: W] = W'(m_r[k]);
            ev = tc;
        end
        sb.push_back(e);
        if (act && en && !sync) act_n++;
        @(posedge clk_i);
        #1;
        cyc++;
        e = sb.pop_front();
        chk("strobe", 64'(strobe_o), 64'(e.strobe));
        chk("rate", 64'(rate_o), 64'(e.rate));
        for (int k = 0; k < N; k++) begin
            if (strobe_o[k]) begin
                s_cnt[k]++;
                last_act[k] = act_n;
            end
        end
    endtask

    task automatic run_acts(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        act_i   = 1'b0;
        sync_i  = 1'b0;
        set_rates(16'd50, 16'd5, 16'd2);
        model_clear();
        tally_clear();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_strobe", 64'(strobe_o), 64'd0);
        chk("reset_rate", 64'(rate_o), 64'd0);
        rst_n_i = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        chk("first_cycle_rate", 64'(rate_o), 64'h0002_0005_0032);

        tbl[0] = '{16'd50, 16'd5, 16'd2, 1000, 0, 20, 4, 2, 1000};
        tbl[1] = '{16'd1,  16'd0, 16'd7, 10,   1, 10, 0, 0, 10};
        tbl[2] = '{16'd3,  16'd2, 16'd0, 12,   0, 4,  2, 0, 12};
        tbl[3] = '{16'd1,  16'd1, 16'd1, 5,    2, 5,  5, 5, 5};
        tbl[4] = '{16'd0,  16'd4, 16'd4, 20,   0, 0,  0, 0, -1};
        tbl[5] = '{16'd7,  16'd3, 16'd2, 42,   2, 6,  2, 1, 42};
        for (int v = 0; v < 6; v++) begin
            set_rates(tbl[v].r0, tbl[v].r1, tbl[v].r2);
            step(1'b1, 1'b0, 1'b1);
            tally_clear();
            run_acts(tbl[v].n_acts, tbl[v].gap);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            chk("vec_cnt0", 64'(s_cnt[0]), 64'(tbl[v].e0));
            chk("vec_cnt1", 64'(s_cnt[1]), 64'(tbl[v].e1));
            chk("vec_cnt2", 64'(s_cnt[2]), 64'(tbl[v].e2));
            chk("vec_last0", 64'(last_act[0]), 64'(tbl[v].last0));
        end

        // Mid-frame rate change only takes effect after the current frame.
        set_rates(16'd50, 16'd5, 16'd2);
        step(1'b1, 1'b0, 1'b1);
        tally_clear();
        run_acts(20, 0);
        set_rates(16'd10, 16'd5, 16'd2);
        run_acts(29, 0);
        chk("chg_no_early", 64'(s_cnt[0]), 64'd0);
        chk("chg_old_rate", 64'(rate_o[W-1:0]), 64'd50);
        run_acts(1, 0);
        chk("chg_wrap50", 64'(last_act[0]), 64'd50);
        chk("chg_new_rate", 64'(rate_o[W-1:0]), 64'd10);
        run_acts(20, 0);
        chk("chg_count", 64'(s_cnt[0]), 64'd3);
        chk("chg_last70", 64'(last_act[0]), 64'd70);

        // Resync coincident with an act discards it and reloads the shadows.
        set_rates(16'd50, 16'd5, 16'd2);
        step(1'b1, 1'b0, 1'b1);
        tally_clear();
        run_acts(30, 0);
        set_rates(16'd50, 16'd6, 16'd2);
        step(1'b1, 1'b1, 1'b1);
        chk("sync_no_strobe", 64'(strobe_o), 64'd0);
        chk("sync_reload", 64'(rate_o[2*W-1:W]), 64'd6);
        tally_clear();
        run_acts(49, 0);
        chk("sync_no_early", 64'(s_cnt[0]), 64'd0);
        run_acts(1, 0);
        chk("sync_full_frame", 64'(s_cnt[0]), 64'd1);

        // Enable low freezes the frame; acts during that window are ignored.
        set_rates(16'd50, 16'd5, 16'd2);
        step(1'b1, 1'b0, 1'b1);
        tally_clear();
        run_acts(30, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("en_frozen", 64'(s_cnt[0]), 64'd0);
        run_acts(19, 0);
        chk("en_no_early", 64'(s_cnt[0]), 64'd0);
        run_acts(1, 0);
        chk("en_resume", 64'(last_act[0]), 64'd50);

        // Asynchronous reset between edges right after a strobe.
        step(1'b1, 1'b0, 1'b1);
        tally_clear();
        run_acts(50, 0);
        chk("pre_rst_strobe", 64'(strobe_o[0]), 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_strobe", 64'(strobe_o), 64'd0);
        chk("async_rst_rate", 64'(rate_o), 64'd0);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        model_clear();
        tally_clear();
        step(1'b1, 1'b0, 1'b0);
        chk("rst_reload", 64'(rate_o), 64'h0002_0005_0032);
        run_acts(49, 0);
        chk("rst_no_early", 64'(s_cnt[0]), 64'd0);
        run_acts(1, 0);
        chk("rst_full_frame", 64'(s_cnt[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
